bus_split_pipe: RTL
===================

# bus_split_pipe

Parametrised, registered successor to the native-bus address splitter. One master port (CPU data or peripheral bus) is routed to `N_SLAVES` slave ports through a registered request stage. The selected slave is held until it responds, and unmapped selects get a deterministic error response. An optional watchdog terminates transactions whose slave never answers. It sits between `dbus`/`pbus` masters and the internal memory, external memory and peripheral slaves.

## Interface
Parameters:
- `N_SLAVES`, default 2: number of slave ports, 1..16.
- `P_SLAVES`, default 31: MSB position of the select field in the address.
- `SEL_W`, default `$clog2(N_SLAVES)` (min 1): select field width; field is `addr[P_SLAVES -: SEL_W]`.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 255: watchdog limit in cycles; used only with the watchdog compiled in.
- `ERR_DATA`, default `32'hDEADBEEF`: rdata returned on error.

Bus formats:
- `REQ_W = 1+ADDR_W+DATA_W+DATA_W/8`, packed as {valid, addr, wdata, wstrb}.
- `RESP_W = DATA_W+1`, packed as {rdata, ready}.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `m_req` in `REQ_W`: master request.
- `m_resp` out `RESP_W`: master response.
- `s_req` out `N_SLAVES*REQ_W`: slave requests; slave k occupies slice k.
- `s_resp` in `N_SLAVES*RESP_W`: slave responses; slave k occupies slice k.
- `err` out 1: one-cycle pulse on each error termination.
- `err_cnt` out 8: saturating count of error terminations.

## Operation
- Protocol: the master holds valid and the request fields stable until it sees ready, and deasserts valid the cycle after ready. Slaves follow the same rule.
- FSM states: IDLE, BUSY, ERR.
- IDLE:
  - On valid with sel < `N_SLAVES`: register the request and the select, go to BUSY.
  - On valid with sel ≥ `N_SLAVES`: go to ERR.
  - Otherwise stay in IDLE.
- BUSY:
  - `s_req[sel]` is driven from the registered request with valid=1; all other slices are all-zero.
  - `m_resp` = `s_resp[sel]` (combinational pass-through).
  - When `s_resp[sel]` ready=1, the registered valid clears on the same edge and the FSM returns to IDLE.
- ERR: for one cycle, `m_resp` = {`ERR_DATA`, 1}, `err`=1, `err_cnt` increments (saturates at 255), then IDLE.
- Writes to unmapped addresses are dropped. Nothing is forwarded to any slave.
- Ready from a non-selected slave, or any ready while IDLE, is ignored. It is never propagated to the master.
- Reset values: all `s_req` = 0, `m_resp` = 0, `err` = 0, `err_cnt` = 0, FSM = IDLE, registered request and select = 0.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately (asynchronous) and slave valid drops. No response is issued to the master.

## Timing
- Request latency: the slave sees valid one cycle after the master asserts it.
- Response latency: 0 cycles from slave ready to `m_resp` ready.
- Minimum transaction: 2 cycles (master valid at cycle 0, zero-wait slave ready at cycle 1).
- Back-to-back: the next request is accepted in IDLE on the cycle after ready. Maximum throughput is one transaction every 2 cycles.
- Unmapped select: the master sees ready exactly 1 cycle after valid.

## Configuration
- `BUS_SPLIT_WATCHDOG_EN` defined:
  - A `$clog2(TIMEOUT+1)`-bit counter clears on entry to BUSY and increments each BUSY cycle without ready.
  - When the count reaches `TIMEOUT`, the FSM goes to ERR: slave valid drops, and the master gets `ERR_DATA` with ready one cycle later. This also pulses `err` and increments `err_cnt`.
  - Slave ready arriving in the same cycle as the limit wins: normal completion, no error.
- Not defined: no counter exists, and BUSY waits indefinitely.

## Structure
- Shared package/header `bus_split_pkg.vh` holds:
  - `REQ_W`/`RESP_W` and the field-slice macros (`valid`, `address`, `wdata`, `wstrb`, `rdata`, `ready`);
  - the FSM state encodings;
  - the default `ERR_DATA`.
- One sub-module, `bus_split_wdog`: the timeout counter (start, busy, done → expired). It is instantiated only under the macro.

## Test plan
- Address `0x0000_0010` with `N_SLAVES`=2, `P_SLAVES`=31, slave 0 with zero-wait ready → slave 0 valid at cycle 1; master ready with slave rdata `0x1234_5678` at cycle 1; slave 1 `s_req` stays 0 throughout.
- `N_SLAVES`=3, `SEL_W`=2, address `0xC000_0000` (sel=3) → master ready at cycle 1 with `0xDEADBEEF`; `err` pulses; `err_cnt`=1; no slave sees valid.
- Slave 1 with a 5-cycle wait, plus a spurious ready from slave 0 during the wait → the spurious ready is ignored; master ready arrives only with slave 1 ready, at cycle 6.
- Watchdog macro on, `TIMEOUT`=4, slave never responds → slave valid drops after 4 BUSY cycles; master gets `ERR_DATA` one cycle later; `err_cnt` increments.
- 300 unmapped accesses → `err_cnt` saturates at 255.
- Reset asserted while BUSY → all outputs 0 asynchronously; after release, a new request completes normally.

Source files
------------

// File: rtl/bus_split_pkg.sv
// bus_split_pkg: bus-format width helpers, field positions, FSM state
// encoding and the default error read data shared by the bus splitter files.
package bus_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

  // Request bus is packed as {valid, addr, wdata, wstrb}
  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Response bus is packed as {rdata, ready}
  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

  // Bit position of the valid flag inside a request
  function automatic int req_valid_pos(input int addr_w, input int data_w);
    return req_width(addr_w, data_w) - 1;
  endfunction

  // LSB of the address field inside a request (above wdata and wstrb)
  function automatic int req_addr_lsb(input int data_w);
    return data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/bus_split_wdog.sv
// bus_split_wdog: transaction timeout counter. Cleared when a transaction
// starts, counts every busy cycle without a slave response, and flags expiry
// in the cycle whose increment would reach TIMEOUT (unless the slave answers
// in that same cycle).
module bus_split_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  input  logic done,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_r;

  // Count busy cycles that did not see the slave answer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (start) begin
      cnt_r <= '0;
    end else if (busy && !done) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = busy && !done && (cnt_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_split_pipe.sv
// bus_split_pipe: registered one-master to N-slave address splitter.
// The request is captured in IDLE, presented to the selected slave while
// BUSY, and the slave response is passed straight back to the master.
// Unmapped selects get a one-cycle ERR_DATA response with an err pulse.
// Optional feature: define BUS_SPLIT_WATCHDOG_EN to abort BUSY after TIMEOUT
// cycles without a slave response.
module bus_split_pipe
  import bus_split_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int P_SLAVES = 31,
  parameter int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEFAULT_ERR_DATA),
  localparam int REQ_W = req_width(ADDR_W, DATA_W),
  localparam int RESP_W = resp_width(DATA_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_W-1:0]           m_req,
  output logic [RESP_W-1:0]          m_resp,
  output logic [N_SLAVES*REQ_W-1:0]  s_req,
  input  logic [N_SLAVES*RESP_W-1:0] s_resp,
  output logic                       err,
  output logic [7:0]                 err_cnt
);

  localparam int VALID_POS = req_valid_pos(ADDR_W, DATA_W);
  localparam int ADDR_LSB  = req_addr_lsb(DATA_W);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [REQ_W-1:0]  req_r;
  logic [SEL_W-1:0]  sel_r;
  logic [7:0]        err_cnt_r;
  logic              m_valid_s;
  logic [SEL_W-1:0]  m_sel_s;
  logic              mapped_s;
  logic [RESP_W-1:0] sel_resp_s;
  logic              slave_ready_s;
  logic              expired_s;

  assign m_valid_s = m_req[VALID_POS];
  assign m_sel_s   = m_req[ADDR_LSB + P_SLAVES -: SEL_W];
  assign mapped_s  = (32'(m_sel_s) < 32'(N_SLAVES));

  // Pick the response slice of the slave that owns the current transaction
  always_comb begin
    sel_resp_s = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      sel_resp_s = (sel_r == SEL_W'(k)) ? s_resp[k*RESP_W +: RESP_W] : sel_resp_s;
    end
  end

  // Ready only counts from the selected slave while a transaction is open
  assign slave_ready_s = (state_r == ST_BUSY) && sel_resp_s[0];

`ifdef BUS_SPLIT_WATCHDOG_EN
  logic start_s;
  logic busy_s;

  assign start_s = (state_r == ST_IDLE) && m_valid_s && mapped_s;
  assign busy_s  = (state_r == ST_BUSY);

  bus_split_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .start   (start_s),
    .busy    (busy_s),
    .done    (sel_resp_s[0]),
    .expired (expired_s)
  );
`else
  assign expired_s = 1'b0;
`endif

  // Only the owning slave sees the registered request; all others see zero
  for (genvar k = 0; k < N_SLAVES; k++) begin : g_slave
    assign s_req[k*REQ_W +: REQ_W] =
      ((state_r == ST_BUSY) && (sel_r == SEL_W'(k))) ? req_r : '0;
  end

  // Next-state decision for the transaction FSM
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (m_valid_s) begin
          state_nxt_s = mapped_s ? ST_BUSY : ST_ERR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (slave_ready_s) begin
          state_nxt_s = ST_IDLE;
        end else if (expired_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Master response: slave pass-through while BUSY, fixed error word in ERR
  always_comb begin
    m_resp = '0;
    case (state_r)
      ST_BUSY: m_resp = sel_resp_s;
      ST_ERR:  m_resp = {ERR_DATA, 1'b1};
      default: m_resp = '0;
    endcase
  end

  assign err     = (state_r == ST_ERR);
  assign err_cnt = err_cnt_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the request on acceptance; drop its valid when the slave finishes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_r <= '0;
      sel_r <= '0;
    end else if ((state_r == ST_IDLE) && m_valid_s && mapped_s) begin
      req_r <= m_req;
      sel_r <= m_sel_s;
    end else if (slave_ready_s || expired_s) begin
      req_r[VALID_POS] <= 1'b0;
    end else begin
      req_r <= req_r;
      sel_r <= sel_r;
    end
  end

  // Saturating error counter, bumped on entry to ERR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_r <= 8'd0;
    end else if ((state_nxt_s == ST_ERR) && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

endmodule
